enregistreur_ad: RTL and testbench

- Write-side address generator for the 128-word sample memory. It records incoming samples at incrementing addresses while in normal (record) mode.
- On leaving record mode it freezes and exports AdMax, the last written address. The review-side address logic uses AdMax as its starting point and steps backwards from it.
- Sits between the sample source and the memory write port, single clock domain.

---
 rtl/enregistreur_ad_pkg.sv | 15 +
 rtl/enregistreur_ad_synchro_2ff.sv | 25 ++
 rtl/enregistreur_ad.sv | 123 ++++++++++++
 tb/tb_enregistreur_ad.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/enregistreur_ad_pkg.sv
// Shared definitions for the sample-memory write-side address generator.
// Holds default widths, the FSM encoding and the memory depth.
package enregistreur_ad_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH      = 1 << ADDR_W_DEF;

  typedef enum logic [1:0] {
    ATTENTE = 2'd0,
    ENREG   = 2'd1,
    PLEIN   = 2'd2
  } etat_t;

endpackage

// File: rtl/enregistreur_ad_synchro_2ff.sv
// Two-flop synchroniser for a slow asynchronous level.
// Both flops clear to 0 on reset.
module synchro_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/enregistreur_ad.sv
// Write-side address generator: records strobed samples at incrementing
// addresses while in record mode and exports the last written address.
module enregistreur_ad
  import enregistreur_ad_pkg::*;
#(
  parameter int MODE   = 1,
  parameter int WRAP   = 0,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              nRst,
  input  logic              Mode,
  input  logic              Effacer,
  input  logic              Echantillon,
  input  logic [DATA_W-1:0] DataIn,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAd,
  output logic [DATA_W-1:0] WrData,
  output logic [ADDR_W-1:0] AdMax,
  output logic              Plein,
  output logic              Vide,
  output logic              Enreg
);

  logic w_pol_mode;
  logic w_mode_s;
  logic w_ptr_last;

  etat_t             r_etat;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_ad;
  logic [DATA_W-1:0] r_wr_data;
  logic [ADDR_W-1:0] r_ad_max;
  logic              r_plein;
  logic              r_vide;
  logic              r_enreg;

  assign w_pol_mode = (MODE != 0) ? Mode : ~Mode;
  assign w_ptr_last = (r_ptr == {ADDR_W{1'b1}});

  synchro_2ff u_sync_mode (
    .clk   (Clk),
    .rst_n (nRst),
    .i_d   (w_pol_mode),
    .o_q   (w_mode_s)
  );

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      r_etat    <= ATTENTE;
      r_ptr     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_ad   <= '0;
      r_wr_data <= '0;
      r_ad_max  <= '0;
      r_plein   <= 1'b0;
      r_vide    <= 1'b1;
      r_enreg   <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_etat)
        ATTENTE: begin
          if (Effacer) begin
            r_ptr    <= '0;
            r_ad_max <= '0;
            r_vide   <= 1'b1;
            r_plein  <= 1'b0;
          end
          // A new session always starts from an empty memory; AdMax keeps
          // the previous value until the first write overwrites it.
          if (w_mode_s) begin
            r_etat  <= ENREG;
            r_enreg <= 1'b1;
            r_ptr   <= '0;
            r_vide  <= 1'b1;
            r_plein <= 1'b0;
          end
        end
        ENREG: begin
          if (!w_mode_s) begin
            r_etat  <= ATTENTE;
            r_enreg <= 1'b0;
          end else if (Echantillon) begin
            r_wr_en   <= 1'b1;
            r_wr_ad   <= r_ptr;
            r_wr_data <= DataIn;
            r_ad_max  <= r_ptr;
            r_ptr     <= r_ptr + 1'b1;
            r_vide    <= 1'b0;
            if (w_ptr_last) begin
              r_plein <= 1'b1;
              if (WRAP == 0) begin
                r_etat  <= PLEIN;
                r_enreg <= 1'b0;
              end
            end
          end
        end
        PLEIN: begin
          if (!w_mode_s) begin
            r_etat  <= ATTENTE;
            r_enreg <= 1'b0;
          end
        end
        default: begin
          r_etat  <= ATTENTE;
          r_enreg <= 1'b0;
        end
      endcase
    end
  end

  assign WrEn   = r_wr_en;
  assign WrAd   = r_wr_ad;
  assign WrData = r_wr_data;
  assign AdMax  = r_ad_max;
  assign Plein  = r_plein;
  assign Vide   = r_vide;
  assign Enreg  = r_enreg;

endmodule

// File: tb/tb_enregistreur_ad.sv
// Directed bench: three instances cover MODE=1/WRAP=0, MODE=1/WRAP=1 and
// MODE=0/WRAP=0; instances a and b share all stimulus, c has its own Mode.
module tb_enregistreur_ad;

  logic       clk;
  logic       n_rst;
  logic       mode_ab;
  logic       mode_c;
  logic       effacer;
  logic       echantillon;
  logic [7:0] data_in;

  logic       a_wr_en, b_wr_en, c_wr_en;
  logic [6:0] a_wr_ad, b_wr_ad, c_wr_ad;
  logic [7:0] a_wr_data, b_wr_data, c_wr_data;
  logic [6:0] a_ad_max, b_ad_max, c_ad_max;
  logic       a_plein, b_plein, c_plein;
  logic       a_vide, b_vide, c_vide;
  logic       a_enreg, b_enreg, c_enreg;

  int n_checks;
  int n_fails;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  enregistreur_ad #(.MODE(1), .WRAP(0), .DATA_W(8), .ADDR_W(7)) u_a (
    .Clk(clk), .nRst(n_rst), .Mode(mode_ab), .Effacer(effacer),
    .Echantillon(echantillon), .DataIn(data_in),
    .WrEn(a_wr_en), .WrAd(a_wr_ad), .WrData(a_wr_data), .AdMax(a_ad_max),
    .Plein(a_plein), .Vide(a_vide), .Enreg(a_enreg)
  );

  enregistreur_ad #(.MODE(1), .WRAP(1), .DATA_W(8), .ADDR_W(7)) u_b (
    .Clk(clk), .nRst(n_rst), .Mode(mode_ab), .Effacer(effacer),
    .Echantillon(echantillon), .DataIn(data_in),
    .WrEn(b_wr_en), .WrAd(b_wr_ad), .WrData(b_wr_data), .AdMax(b_ad_max),
    .Plein(b_plein), .Vide(b_vide), .Enreg(b_enreg)
  );

  enregistreur_ad #(.MODE(0), .WRAP(0), .DATA_W(8), .ADDR_W(7)) u_c (
    .Clk(clk), .nRst(n_rst), .Mode(mode_c), .Effacer(effacer),
    .Echantillon(echantillon), .DataIn(data_in),
    .WrEn(c_wr_en), .WrAd(c_wr_ad), .WrData(c_wr_data), .AdMax(c_ad_max),
    .Plein(c_plein), .Vide(c_vide), .Enreg(c_enreg)
  );

  // driver tasks
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    n_rst       = 1'b0;
    mode_ab     = 1'b0;
    mode_c      = 1'b1;
    effacer     = 1'b0;
    echantillon = 1'b0;
    data_in     = 8'h00;

    // reset state
    cyc(2);
    check("rst_a_wren",  32'(a_wr_en), 32'd0);
    check("rst_a_wrad",  32'(a_wr_ad), 32'd0);
    check("rst_a_admax", 32'(a_ad_max), 32'd0);
    check("rst_a_plein", 32'(a_plein), 32'd0);
    check("rst_a_vide",  32'(a_vide), 32'd1);
    check("rst_a_enreg", 32'(a_enreg), 32'd0);
    n_rst = 1'b1;
    cyc(2);

    // basic record: 2-cycle sync then FSM edge
    mode_ab = 1'b1;
    cyc(2);
    check("start_enreg_early", 32'(a_enreg), 32'd0);
    cyc(1);
    check("start_enreg", 32'(a_enreg), 32'd1);
    check("start_c_idle", 32'(c_enreg), 32'd0);
    for (int i = 0; i < 5; i++) begin
      echantillon = 1'b1;
      data_in     = 8'h10 + 8'(i);
      cyc(1);
      check("basic_wren",   32'(a_wr_en), 32'd1);
      check("basic_wrad",   32'(a_wr_ad), 32'(i));
      check("basic_wrdata", 32'(a_wr_data), 32'h10 + 32'(i));
      check("basic_c_nowr", 32'(c_wr_en), 32'd0);
      echantillon = 1'b0;
      cyc(1);
      check("basic_wren_low", 32'(a_wr_en), 32'd0);
    end
    check("basic_vide", 32'(a_vide), 32'd0);
    mode_ab = 1'b0;
    cyc(2);
    check("stop_enreg_pending", 32'(a_enreg), 32'd1);
    cyc(1);
    check("stop_enreg", 32'(a_enreg), 32'd0);
    check("stop_a_admax", 32'(a_ad_max), 32'd4);
    check("stop_b_admax", 32'(b_ad_max), 32'd4);

    // Effacer in ATTENTE
    effacer = 1'b1;
    cyc(1);
    effacer = 1'b0;
    check("eff_admax", 32'(a_ad_max), 32'd0);
    check("eff_vide",  32'(a_vide), 32'd1);

    // full (a) and wrap (b) with back-to-back strobes
    mode_ab = 1'b1;
    cyc(3);
    check("full_enreg", 32'(a_enreg), 32'd1);
    echantillon = 1'b1;
    for (int i = 0; i < 130; i++) begin
      data_in = 8'(i);
      cyc(1);
      if (i < 128) begin
        check("full_a_wren", 32'(a_wr_en), 32'd1);
        check("full_a_wrad", 32'(a_wr_ad), 32'(i));
      end else begin
        check("full_a_nowr", 32'(a_wr_en), 32'd0);
      end
      check("wrap_b_wren", 32'(b_wr_en), 32'd1);
      check("wrap_b_wrad", 32'(b_wr_ad), 32'(i % 128));
    end
    echantillon = 1'b0;
    check("wrap_b_wrdata", 32'(b_wr_data), 32'd129);
    cyc(1);
    check("full_a_plein", 32'(a_plein), 32'd1);
    check("full_a_admax", 32'(a_ad_max), 32'd127);
    check("full_a_enreg", 32'(a_enreg), 32'd0);
    check("full_a_wrdata", 32'(a_wr_data), 32'd127);
    check("wrap_b_plein", 32'(b_plein), 32'd1);
    check("wrap_b_admax", 32'(b_ad_max), 32'd1);
    check("wrap_b_enreg", 32'(b_enreg), 32'd1);

    // edge timing on b: strobe seen while ModeS still 1 writes, next one dropped
    mode_ab = 1'b0;
    cyc(1);
    echantillon = 1'b1;
    data_in     = 8'hAA;
    cyc(1);
    check("edge_b_wren",  32'(b_wr_en), 32'd1);
    check("edge_b_wrad",  32'(b_wr_ad), 32'd2);
    check("edge_b_admax", 32'(b_ad_max), 32'd2);
    check("edge_a_nowr",  32'(a_wr_en), 32'd0);
    data_in = 8'hBB;
    cyc(1);
    echantillon = 1'b0;
    check("edge_b_drop",  32'(b_wr_en), 32'd0);
    check("edge_b_admax_held", 32'(b_ad_max), 32'd2);
    check("edge_b_enreg", 32'(b_enreg), 32'd0);
    check("edge_b_wrdata", 32'(b_wr_data), 32'hAA);
    check("held_a_plein", 32'(a_plein), 32'd1);
    check("held_a_admax", 32'(a_ad_max), 32'd127);
    check("held_a_enreg", 32'(a_enreg), 32'd0);

    // polarity MODE=0 on c: Mode low records
    check("pol_c_vide", 32'(c_vide), 32'd1);
    mode_c = 1'b0;
    cyc(3);
    check("pol_c_enreg", 32'(c_enreg), 32'd1);
    effacer = 1'b1;
    cyc(1);
    effacer = 1'b0;
    check("pol_c_eff_ignored", 32'(c_enreg), 32'd1);
    check("eff_a_plein_clr", 32'(a_plein), 32'd0);
    check("eff_a_admax_clr", 32'(a_ad_max), 32'd0);
    for (int i = 0; i < 3; i++) begin
      echantillon = 1'b1;
      data_in     = 8'h20 + 8'(i);
      cyc(1);
      check("pol_c_wren",   32'(c_wr_en), 32'd1);
      check("pol_c_wrad",   32'(c_wr_ad), 32'(i));
      check("pol_c_wrdata", 32'(c_wr_data), 32'h20 + 32'(i));
      check("pol_a_nowr",   32'(a_wr_en), 32'd0);
      echantillon = 1'b0;
      cyc(1);
    end
    mode_c = 1'b1;
    cyc(3);
    check("pol_c_stop",  32'(c_enreg), 32'd0);
    check("pol_c_admax", 32'(c_ad_max), 32'd2);
    check("pol_c_vide0", 32'(c_vide), 32'd0);
    effacer = 1'b1;
    cyc(1);
    effacer = 1'b0;
    check("pol_c_eff_admax", 32'(c_ad_max), 32'd0);
    check("pol_c_eff_vide",  32'(c_vide), 32'd1);

    // reset mid-write: WrEn drops without a clock edge
    mode_ab = 1'b1;
    cyc(3);
    echantillon = 1'b1;
    data_in     = 8'h55;
    cyc(1);
    echantillon = 1'b0;
    check("mid_wren_before", 32'(a_wr_en), 32'd1);
    #1;
    n_rst = 1'b0;
    #1;
    check("mid_wren",  32'(a_wr_en), 32'd0);
    check("mid_wrad",  32'(a_wr_ad), 32'd0);
    check("mid_wrdata", 32'(a_wr_data), 32'd0);
    check("mid_admax", 32'(a_ad_max), 32'd0);
    check("mid_vide",  32'(a_vide), 32'd1);
    check("mid_enreg", 32'(a_enreg), 32'd0);
    check("mid_plein", 32'(b_plein), 32'd0);
    mode_ab = 1'b0;
    cyc(1);
    n_rst = 1'b1;
    cyc(2);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
